m_dm: RTL and testbench

- Data memory for the M stage of the 5-stage MIPS pipeline; the writable, load/store counterpart to the read-only instruction fetch path.
- Word-organised array with one synchronous write port and one combinational read port.
- Stores are sub-word (byte/half) merges into the addressed word; loads return the addressed word/half/byte with sign or zero extension.
- Address alignment and range are checked every access; a faulting access never writes.

---
 rtl/m_dm_if.sv | 14 +
 rtl/m_dm.sv | 96 +++++++++
 tb/tb_m_dm.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/m_dm_if.sv
// Bus bundle between the M-stage pipeline logic and the data memory m_dm.
// The master drives the access request; the slave returns the load result and fault flag.
interface m_dm_if;
   logic        we;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] pc;
   logic [31:0] rdata;
   logic        err;

   modport master (output we, op, addr, wdata, pc, input rdata, err);
   modport slave  (input we, op, addr, wdata, pc, output rdata, err);
endinterface

// File: rtl/m_dm.sv
// M-stage data memory: word array, synchronous sub-word merging store, combinational extending load.
// Optional macro DM_WRITE_TRACE_EN prints one trace line per committed store.
module m_dm #(
   parameter int DEPTH_WORDS = 4096,
   parameter int IDX_W       = 12
) (
   input logic    clk,
   input logic    reset,
   m_dm_if.slave  bus
);

   localparam logic [2:0] OP_W  = 3'd0;
   localparam logic [2:0] OP_H  = 3'd1;
   localparam logic [2:0] OP_HU = 3'd2;
   localparam logic [2:0] OP_B  = 3'd3;
   localparam logic [2:0] OP_BU = 3'd4;
   localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

   logic [31:0]      mem [DEPTH_WORDS];
   logic [IDX_W-1:0] idx;
   logic [1:0]       lane;
   logic [31:0]      cur_word;
   logic [31:0]      merged;
   logic [15:0]      half_sel;
   logic [7:0]       byte_sel;
   logic             fault;

   assign idx      = bus.addr[IDX_W+1:2];
   assign lane     = bus.addr[1:0];
   assign cur_word = mem[idx];
   assign half_sel = lane[1] ? cur_word[31:16] : cur_word[15:0];
   assign byte_sel = cur_word[{lane, 3'b000} +: 8];

   always_comb begin
      fault = 1'b0;
      if ({1'b0, bus.addr} >= BYTE_LIMIT) begin
         fault = 1'b1;
      end
      case (bus.op)
         OP_W:        if (lane != 2'b00) fault = 1'b1;
         OP_H, OP_HU: if (lane[0])       fault = 1'b1;
         OP_B, OP_BU: ;
         default:     fault = 1'b1;
      endcase
   end

   assign bus.err = fault;

   // Unsigned store ops behave exactly like their signed twins; extension only matters on loads.
   always_comb begin
      merged = cur_word;
      case (bus.op)
         OP_W: merged = bus.wdata;
         OP_H, OP_HU: begin
            if (lane[1]) merged[31:16] = bus.wdata[15:0];
            else         merged[15:0]  = bus.wdata[15:0];
         end
         OP_B, OP_BU: merged[{lane, 3'b000} +: 8] = bus.wdata[7:0];
         default: merged = cur_word;
      endcase
   end

   always_comb begin
      bus.rdata = 32'h0;
      if (!fault) begin
         case (bus.op)
            OP_W:    bus.rdata = cur_word;
            OP_H:    bus.rdata = {{16{half_sel[15]}}, half_sel};
            OP_HU:   bus.rdata = {16'h0, half_sel};
            OP_B:    bus.rdata = {{24{byte_sel[7]}}, byte_sel};
            OP_BU:   bus.rdata = {24'h0, byte_sel};
            default: bus.rdata = 32'h0;
         endcase
      end
   end

   // No bypass: a load in the store cycle sees the old word; forwarding is the pipeline's job.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] <= 32'h0;
         end
      end else if (bus.we && !fault) begin
         mem[idx] <= merged;
`ifdef DM_WRITE_TRACE_EN
         $display("%0t@%08h: *%08h <= %08h", $time, bus.pc, {bus.addr[31:2], 2'b00}, merged);
`endif
      end
   end

`ifndef DM_WRITE_TRACE_EN
   logic unused_pc;
   assign unused_pc = ^bus.pc;
`endif

endmodule

// File: tb/tb_m_dm.sv
// Self-checking bench for m_dm: byte-level reference model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_m_dm;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   bit   compare_en;

   m_dm_if bus ();

   m_dm #(.DEPTH_WORDS(4096), .IDX_W(12)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] model_mem [int unsigned];

   function automatic bit model_err(input logic [2:0] op, input logic [31:0] addr);
      if (addr >= 32'h4000) return 1'b1;
      if (op > 3'd4) return 1'b1;
      if (op == 3'd0 && (addr % 4) != 0) return 1'b1;
      if ((op == 3'd1 || op == 3'd2) && (addr % 2) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] addr);
      int unsigned k;
      k = addr / 4;
      if (model_mem.exists(k)) return model_mem[k];
      return 32'h0;
   endfunction

   function automatic logic [31:0] model_read(input logic [2:0] op, input logic [31:0] addr);
      logic [31:0] w;
      logic [31:0] piece;
      if (model_err(op, addr)) return 32'h0;
      w = model_word(addr);
      case (op)
         3'd0: return w;
         3'd1, 3'd2: begin
            piece = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
            if (op == 3'd1 && piece >= 32'h8000) piece = piece + 32'hFFFF_0000;
            return piece;
         end
         default: begin
            piece = (w >> (8 * (addr % 4))) & 32'hFF;
            if (op == 3'd3 && piece >= 32'h80) piece = piece + 32'hFFFF_FF00;
            return piece;
         end
      endcase
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         model_mem.delete();
      end else if (bus.we && !model_err(bus.op, bus.addr)) begin
         logic [31:0] w;
         logic [31:0] mask;
         int          sh;
         w = model_word(bus.addr);
         case (bus.op)
            3'd0: w = bus.wdata;
            3'd1, 3'd2: begin
               sh   = 16 * ((bus.addr / 2) % 2);
               mask = 32'hFFFF << sh;
               w    = (w & ~mask) | ((bus.wdata & 32'hFFFF) << sh);
            end
            default: begin
               sh   = 8 * (bus.addr % 4);
               mask = 32'hFF << sh;
               w    = (w & ~mask) | ((bus.wdata & 32'hFF) << sh);
            end
         endcase
         model_mem[bus.addr / 4] = w;
      end
   end

   // Outputs are combinational and always meaningful once the array has been reset.
   always @(negedge clk) begin
      if (compare_en) begin
         n_checks++;
         if (bus.rdata !== model_read(bus.op, bus.addr) || bus.err !== model_err(bus.op, bus.addr)) begin
            n_fail++;
            $display("[TB] FAIL model op=%0d addr=%08h: got rdata=%08h err=%b, want rdata=%08h err=%b",
                     bus.op, bus.addr, bus.rdata, bus.err,
                     model_read(bus.op, bus.addr), model_err(bus.op, bus.addr));
         end
      end
   end

   task automatic applyStimulus(input logic st, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic rst);
      @(posedge clk);
      #1;
      bus.we    = st;
      bus.op    = op;
      bus.addr  = addr;
      bus.wdata = wdata;
      bus.pc    = 32'h0040_0000 + addr;
      reset     = rst;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] exp_rdata, input logic exp_err);
      #1;
      n_checks++;
      if (bus.rdata !== exp_rdata || bus.err !== exp_err) begin
         n_fail++;
         $display("[TB] FAIL %s: got rdata=%08h err=%b, want rdata=%08h err=%b",
                  name, bus.rdata, bus.err, exp_rdata, exp_err);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      compare_en = 1'b0;
      reset      = 1'b1;
      bus.we     = 1'b0;
      bus.op     = 3'd0;
      bus.addr   = 32'h0;
      bus.wdata  = 32'h0;
      bus.pc     = 32'h0;

      applyStimulus(1'b0, 3'd0, 32'h10, 32'h0, 1'b1);
      applyStimulus(1'b0, 3'd0, 32'h10, 32'h0, 1'b0);
      compare_en = 1'b1;
      checkOutput("reset_read", 32'h0000_0000, 1'b0);

      applyStimulus(1'b1, 3'd0, 32'h4, 32'h1234_5678, 1'b0);
      applyStimulus(1'b0, 3'd0, 32'h4, 32'h0, 1'b0);
      checkOutput("sw_lw", 32'h1234_5678, 1'b0);

      applyStimulus(1'b1, 3'd3, 32'h6, 32'h0000_00AB, 1'b0);
      applyStimulus(1'b0, 3'd0, 32'h4, 32'h0, 1'b0);
      checkOutput("sb_merge", 32'h12AB_5678, 1'b0);

      applyStimulus(1'b1, 3'd1, 32'h4, 32'hFFFF_8001, 1'b0);
      checkOutput("rdw_old", 32'h0000_5678, 1'b0);
      applyStimulus(1'b0, 3'd0, 32'h4, 32'h0, 1'b0);
      checkOutput("sh_merge", 32'h12AB_8001, 1'b0);

      applyStimulus(1'b0, 3'd3, 32'h4, 32'h0, 1'b0);
      checkOutput("lb_4", 32'h0000_0001, 1'b0);
      applyStimulus(1'b0, 3'd1, 32'h4, 32'h0, 1'b0);
      checkOutput("lh_4", 32'hFFFF_8001, 1'b0);
      applyStimulus(1'b0, 3'd2, 32'h4, 32'h0, 1'b0);
      checkOutput("lhu_4", 32'h0000_8001, 1'b0);
      applyStimulus(1'b0, 3'd3, 32'h6, 32'h0, 1'b0);
      checkOutput("lb_6", 32'hFFFF_FFAB, 1'b0);
      applyStimulus(1'b0, 3'd4, 32'h6, 32'h0, 1'b0);
      checkOutput("lbu_6", 32'h0000_00AB, 1'b0);
      applyStimulus(1'b0, 3'd1, 32'h6, 32'h0, 1'b0);
      checkOutput("lh_6", 32'h0000_12AB, 1'b0);

      applyStimulus(1'b1, 3'd0, 32'h6, 32'hDEAD_BEEF, 1'b0);
      checkOutput("sw_misaligned", 32'h0, 1'b1);
      applyStimulus(1'b0, 3'd0, 32'h4, 32'h0, 1'b0);
      checkOutput("after_fault", 32'h12AB_8001, 1'b0);

      applyStimulus(1'b1, 3'd1, 32'h5, 32'h0000_7777, 1'b0);
      checkOutput("sh_misaligned", 32'h0, 1'b1);
      applyStimulus(1'b0, 3'd0, 32'h4000, 32'h0, 1'b0);
      checkOutput("out_of_range", 32'h0, 1'b1);
      applyStimulus(1'b0, 3'd5, 32'h4, 32'h0, 1'b0);
      checkOutput("reserved_op", 32'h0, 1'b1);
      applyStimulus(1'b0, 3'd4, 32'h4003, 32'h0, 1'b0);
      checkOutput("byte_out_of_range", 32'h0, 1'b1);

      // Back-to-back byte stores into the last word, merged one per cycle.
      applyStimulus(1'b1, 3'd4, 32'h3FFC, 32'h0000_0011, 1'b0);
      applyStimulus(1'b1, 3'd3, 32'h3FFD, 32'hFFFF_FF22, 1'b0);
      applyStimulus(1'b1, 3'd2, 32'h3FFE, 32'h0000_8833, 1'b0);
      applyStimulus(1'b0, 3'd0, 32'h3FFC, 32'h0, 1'b0);
      checkOutput("last_word_merge", 32'h8833_2211, 1'b0);
      applyStimulus(1'b0, 3'd3, 32'h3FFF, 32'h0, 1'b0);
      checkOutput("lb_last_byte", 32'hFFFF_FF88, 1'b0);

      applyStimulus(1'b1, 3'd0, 32'h8, 32'hCAFE_F00D, 1'b1);
      applyStimulus(1'b0, 3'd0, 32'h8, 32'h0, 1'b0);
      checkOutput("reset_collision", 32'h0, 1'b0);
      applyStimulus(1'b0, 3'd0, 32'h4, 32'h0, 1'b0);
      checkOutput("reset_clears_4", 32'h0, 1'b0);
      applyStimulus(1'b0, 3'd0, 32'h3FFC, 32'h0, 1'b0);
      checkOutput("reset_clears_last", 32'h0, 1'b0);

      @(posedge clk);
      #1;
      compare_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
